// File: rtl/ccm_pkg.sv
// rtl/ccm_pkg.sv - shared widths and FSM encoding for the CCM counter-mode scheduler
package ccm_pkg;

    localparam int DEF_WIDTH_NONCE = 100;
    localparam int DEF_WIDTH_FLAG  = 8;
    localparam int DEF_WIDTH_COUNT = 20;
    localparam int AES_BLOCK       = 128;
    localparam int BLK_BYTES       = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE_S0,
        ST_WAIT_S0,
        ST_COLLECT,
        ST_ISSUE,
        ST_WAIT
    } ccm_state_e;

endpackage

// File: rtl/ccm_ctr_blk_gen.sv
// rtl/ccm_ctr_blk_gen.sv - counter register with wrap detect and {flag, nonce, count} block assembly
module ccm_ctr_blk_gen
    import ccm_pkg::*;
#(
    parameter int WIDTH_NONCE = DEF_WIDTH_NONCE,
    parameter int WIDTH_FLAG  = DEF_WIDTH_FLAG,
    parameter int WIDTH_COUNT = DEF_WIDTH_COUNT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load_i,
    input  logic                   inc_i,
    input  logic                   snap_i,
    input  logic [WIDTH_NONCE-1:0] nonce_i,
    input  logic [WIDTH_FLAG-1:0]  flag_i,
    output logic [AES_BLOCK-1:0]   block_o,
    output logic                   overflow_o
);

    logic [WIDTH_NONCE-1:0] nonce_q, nonce_d;
    logic [WIDTH_FLAG-1:0]  flag_q, flag_d;
    logic [WIDTH_COUNT-1:0] count_q, count_d;
    logic                   ovf_q, ovf_d;
    logic [AES_BLOCK-1:0]   block_q, block_d;

    always_comb begin
        nonce_d = nonce_q;
        flag_d  = flag_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        block_d = block_q;
        if (load_i) begin
            nonce_d = nonce_i;
            flag_d  = flag_i;
            count_d = '0;
            ovf_d   = 1'b0;
        end else if (inc_i) begin
            count_d = count_q + WIDTH_COUNT'(1);
            if (&count_q) begin
                ovf_d = 1'b1;
            end
        end
        // Snapshot uses next-state values so a block issued right after start carries the new nonce/flag.
        if (snap_i) begin
            block_d = {flag_d, nonce_d, count_d};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            nonce_q <= '0;
            flag_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            block_q <= '0;
        end else begin
            nonce_q <= nonce_d;
            flag_q  <= flag_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            block_q <= block_d;
        end
    end

    assign block_o    = block_q;
    assign overflow_o = ovf_q;

endmodule

// File: rtl/ccm_ctr_sched.sv
// rtl/ccm_ctr_sched.sv - CCM counter-block sequencer pacing the byte stream against AES keystream
module ccm_ctr_sched
    import ccm_pkg::*;
#(
    parameter int WIDTH_NONCE = DEF_WIDTH_NONCE,
    parameter int WIDTH_FLAG  = DEF_WIDTH_FLAG,
    parameter int WIDTH_COUNT = DEF_WIDTH_COUNT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [WIDTH_NONCE-1:0] ccm_ctr_nonce,
    input  logic [WIDTH_FLAG-1:0]  ccm_ctr_flag,
    input  logic                   input_en,
    input  logic                   input_last,
    output logic                   out_ready,
    output logic                   aes_in_en,
    output logic [AES_BLOCK-1:0]   aes_in_block,
    input  logic                   aes_out_en,
    output logic                   s0_valid,
    output logic                   ks_valid,
    output logic [4:0]             blk_bytes,
    output logic                   blk_last,
    output logic                   ctr_overflow
);

    ccm_state_e state_q, state_d;
    logic [4:0] byte_cnt_q, byte_cnt_d;
    logic [4:0] blk_bytes_q, blk_bytes_d;
    logic       blk_last_q, blk_last_d;
    logic       load, inc, snap;

    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        blk_bytes_d = blk_bytes_q;
        blk_last_d  = blk_last_q;
        load        = 1'b0;
        inc         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = ST_ISSUE_S0;
                end
            end
            ST_ISSUE_S0: state_d = ST_WAIT_S0;
            ST_WAIT_S0: begin
                if (aes_out_en) begin
                    inc        = 1'b1;
                    byte_cnt_d = '0;
                    state_d    = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (input_en) begin
                    byte_cnt_d = byte_cnt_q + 5'd1;
                    if (input_last || byte_cnt_q == 5'(BLK_BYTES - 1)) begin
                        blk_bytes_d = byte_cnt_q + 5'd1;
                        blk_last_d  = input_last;
                        state_d     = ST_ISSUE;
                    end
                end else if (input_last) begin
                    // A bare close on an empty block ends the message without another keystream block.
                    if (byte_cnt_q == '0) begin
                        state_d = ST_IDLE;
                    end else begin
                        blk_bytes_d = byte_cnt_q;
                        blk_last_d  = 1'b1;
                        state_d     = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: begin
                if (aes_out_en) begin
                    inc = 1'b1;
                    if (blk_last_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        byte_cnt_d = '0;
                        state_d    = ST_COLLECT;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign snap = (state_d == ST_ISSUE_S0) || (state_d == ST_ISSUE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            byte_cnt_q  <= '0;
            blk_bytes_q <= '0;
            blk_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            blk_bytes_q <= blk_bytes_d;
            blk_last_q  <= blk_last_d;
        end
    end

    ccm_ctr_blk_gen #(
        .WIDTH_NONCE (WIDTH_NONCE),
        .WIDTH_FLAG  (WIDTH_FLAG),
        .WIDTH_COUNT (WIDTH_COUNT)
    ) u_blk_gen (
        .clk        (clk),
        .reset      (reset),
        .load_i     (load),
        .inc_i      (inc),
        .snap_i     (snap),
        .nonce_i    (ccm_ctr_nonce),
        .flag_i     (ccm_ctr_flag),
        .block_o    (aes_in_block),
        .overflow_o (ctr_overflow)
    );

    assign out_ready = (state_q == ST_COLLECT);
    assign aes_in_en = (state_q == ST_ISSUE_S0) || (state_q == ST_ISSUE);
    assign s0_valid  = (state_q == ST_WAIT_S0) && aes_out_en;
    assign ks_valid  = (state_q == ST_WAIT) && aes_out_en;
    assign blk_bytes = blk_bytes_q;
    assign blk_last  = blk_last_q;

endmodule

// File: tb/tb_ccm_ctr_sched.sv
// tb/tb_ccm_ctr_sched.sv - directed vector bench for ccm_ctr_sched with a 12-cycle AES responder
module tb_ccm_ctr_sched;

    localparam logic [127:0] S0_LIT = 128'h5900_0000_0000_0000_0000_0000_0050_0000;

    logic clk = 1'b0, reset = 1'b1, start0 = 1'b0, start1 = 1'b0;
    logic input_en = 1'b0, input_last = 1'b0;
    logic aes_out_en0 = 1'b0, aes_out_en1 = 1'b0;
    logic [99:0]  nonce0 = '0;
    logic [117:0] nonce1 = '0;
    logic [7:0]   flag0 = '0, flag1 = '0;

    logic         out_ready0, aes_in_en0, s0_valid0, ks_valid0, blk_last0, ctr_overflow0;
    logic         out_ready1, aes_in_en1, s0_valid1, ks_valid1, blk_last1, ctr_overflow1;
    logic [127:0] aes_in_block0, aes_in_block1;
    logic [4:0]   blk_bytes0, blk_bytes1;

    always #5 clk = ~clk;

    ccm_ctr_sched dut0 (
        .clk(clk), .reset(reset), .start(start0), .ccm_ctr_nonce(nonce0), .ccm_ctr_flag(flag0),
        .input_en(input_en), .input_last(input_last), .out_ready(out_ready0), .aes_in_en(aes_in_en0),
        .aes_in_block(aes_in_block0), .aes_out_en(aes_out_en0), .s0_valid(s0_valid0), .ks_valid(ks_valid0),
        .blk_bytes(blk_bytes0), .blk_last(blk_last0), .ctr_overflow(ctr_overflow0)
    );

    ccm_ctr_sched #(.WIDTH_NONCE(118), .WIDTH_FLAG(8), .WIDTH_COUNT(2)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .ccm_ctr_nonce(nonce1), .ccm_ctr_flag(flag1),
        .input_en(input_en), .input_last(input_last), .out_ready(out_ready1), .aes_in_en(aes_in_en1),
        .aes_in_block(aes_in_block1), .aes_out_en(aes_out_en1), .s0_valid(s0_valid1), .ks_valid(ks_valid1),
        .blk_bytes(blk_bytes1), .blk_last(blk_last1), .ctr_overflow(ctr_overflow1)
    );

    // AES core stand-ins: keystream returns 12 cycles after each issue, regardless of DUT state.
    initial begin
        int rsp = 0;
        forever begin
            @(negedge clk);
            aes_out_en0 = 1'b0;
            if (rsp > 0) begin
                rsp--;
                if (rsp == 0) aes_out_en0 = 1'b1;
            end
            if (aes_in_en0) rsp = 12;
        end
    end

    initial begin
        int rsp = 0;
        forever begin
            @(negedge clk);
            aes_out_en1 = 1'b0;
            if (rsp > 0) begin
                rsp--;
                if (rsp == 0) aes_out_en1 = 1'b1;
            end
            if (aes_in_en1) rsp = 12;
        end
    end

    bit           sel = 1'b0;
    logic         or_s, ain_s, s0_s, ks_s, last_s, ovf_s;
    logic [4:0]   bb_s;
    logic [127:0] blk_s;

    always_comb begin
        if (sel) begin
            or_s = out_ready1; ain_s = aes_in_en1; s0_s = s0_valid1; ks_s = ks_valid1;
            last_s = blk_last1; ovf_s = ctr_overflow1; bb_s = blk_bytes1; blk_s = aes_in_block1;
        end else begin
            or_s = out_ready0; ain_s = aes_in_en0; s0_s = s0_valid0; ks_s = ks_valid0;
            last_s = blk_last0; ovf_s = ctr_overflow0; bb_s = blk_bytes0; blk_s = aes_in_block0;
        end
    end

    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_rst(input string p);
        chk({p, ".out_ready"}, 128'(or_s), 128'(0));
        chk({p, ".aes_in_en"}, 128'(ain_s), 128'(0));
        chk({p, ".aes_in_block"}, blk_s, 128'(0));
        chk({p, ".s0_valid"}, 128'(s0_s), 128'(0));
        chk({p, ".ks_valid"}, 128'(ks_s), 128'(0));
        chk({p, ".blk_bytes"}, 128'(bb_s), 128'(0));
        chk({p, ".blk_last"}, 128'(last_s), 128'(0));
        chk({p, ".ctr_overflow"}, 128'(ovf_s), 128'(0));
    endtask

    int           n_issue, n_s0, n_ks, n_acc, or_bad, n_extra;
    bit           timed_out;
    logic [127:0] iss_blk [16];
    logic         iss_ovf [16];
    logic [4:0]   ks_bytes [16];
    logic         ks_last [16];

    // One message: start pulse, then a source that holds each byte until accepted.
    // exp_or is the bench's own view of when the scheduler should be collecting.
    task automatic msg(input int nbytes, input bit sep_last, input int stop_issue);
        int inblk = 0;
        bit exp_or = 1'b0, fin = 1'b0, done = 1'b0, last_done = 1'b0, stop = 1'b0, acc, nxt;
        n_issue = 0; n_s0 = 0; n_ks = 0; n_acc = 0; or_bad = 0; n_extra = 0; timed_out = 1'b0;
        for (int c = 0; c < 2000 && !done && !stop; c++) begin
            @(negedge clk);
            if (sel) start1 = (c == 0); else start0 = (c == 0);
            input_en   = (c > 0) && (n_acc < nbytes);
            input_last = (c > 0) && (sep_last ? (n_acc >= nbytes && !last_done) : (n_acc == nbytes - 1));
            #1;
            if (or_s !== exp_or) or_bad++;
            if (ain_s && n_issue < 16) begin
                iss_blk[n_issue] = blk_s;
                iss_ovf[n_issue] = ovf_s;
            end
            if (ain_s) n_issue++;
            if (s0_s) n_s0++;
            if (ks_s && n_ks < 16) begin
                ks_bytes[n_ks] = bb_s;
                ks_last[n_ks]  = last_s;
            end
            if (ks_s) n_ks++;
            acc = or_s && input_en;
            nxt = exp_or;
            if (acc) begin
                n_acc++;
                inblk++;
                if (inblk == 16 || input_last) begin
                    nxt = 1'b0;
                    fin = input_last;
                end
            end else if (or_s && input_last) begin
                nxt = 1'b0;
                fin = 1'b1;
                last_done = 1'b1;
                if (inblk == 0) done = 1'b1;
            end
            if (s0_s || (ks_s && !fin)) begin
                nxt = 1'b1;
                inblk = 0;
            end
            if (ks_s && fin) done = 1'b1;
            exp_or = nxt;
            if (stop_issue > 0 && n_issue >= stop_issue) stop = 1'b1;
        end
        if (!done && !stop) timed_out = 1'b1;
        if (done) begin
            for (int c = 0; c < 20; c++) begin
                @(negedge clk);
                input_en = 1'b0;
                input_last = 1'b0;
                #1;
                if (ain_s || ks_s || s0_s || or_s) n_extra++;
            end
        end
    endtask

    typedef struct {
        int nbytes;
        bit sep_last;
        int exp_blks;
        int exp_tail;
        bit exp_flast;
    } vec_t;

    initial begin
        vec_t vt [6];
        vt[0] = '{32, 1'b0, 2, 16, 1'b1};
        vt[1] = '{34, 1'b0, 3,  2, 1'b1};
        vt[2] = '{16, 1'b1, 1, 16, 1'b0};
        vt[3] = '{20, 1'b1, 2,  4, 1'b1};
        vt[4] = '{ 1, 1'b0, 1,  1, 1'b1};
        vt[5] = '{17, 1'b0, 2,  1, 1'b1};

        @(negedge clk);
        @(negedge clk);
        #1;
        sel = 1'b0;
        #1;
        chk_rst("rst0");
        sel = 1'b1;
        #1;
        chk_rst("rst1");
        sel = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        flag0 = 8'h59;
        for (int r = 0; r < 6; r++) begin
            nonce0 = 100'h5 + 100'(r);
            msg(vt[r].nbytes, vt[r].sep_last, 0);
            chk($sformatf("r%0d.timeout", r), 128'(timed_out), 128'(0));
            chk($sformatf("r%0d.n_s0", r), 128'(n_s0), 128'(1));
            chk($sformatf("r%0d.n_issue", r), 128'(n_issue), 128'(vt[r].exp_blks + 1));
            chk($sformatf("r%0d.n_ks", r), 128'(n_ks), 128'(vt[r].exp_blks));
            chk($sformatf("r%0d.n_acc", r), 128'(n_acc), 128'(vt[r].nbytes));
            chk($sformatf("r%0d.out_ready_pace", r), 128'(or_bad), 128'(0));
            chk($sformatf("r%0d.after_end", r), 128'(n_extra), 128'(0));
            if (r == 0) chk("r0.s0_block", iss_blk[0], S0_LIT);
            for (int i = 0; i <= vt[r].exp_blks && i < n_issue && i < 16; i++)
                chk($sformatf("r%0d.blk%0d", r, i), iss_blk[i], {flag0, nonce0, 20'(i)});
            for (int i = 0; i < vt[r].exp_blks && i < n_ks && i < 16; i++) begin
                chk($sformatf("r%0d.bytes%0d", r, i), 128'(ks_bytes[i]),
                    128'((i == vt[r].exp_blks - 1) ? vt[r].exp_tail : 16));
                chk($sformatf("r%0d.last%0d", r, i), 128'(ks_last[i]),
                    128'((i == vt[r].exp_blks - 1) ? vt[r].exp_flast : 1'b0));
            end
        end

        sel = 1'b1;
        nonce1 = 118'h3;
        flag1 = 8'hA5;
        msg(80, 1'b0, 5);
        chk("w2.timeout", 128'(timed_out), 128'(0));
        chk("w2.n_ks", 128'(n_ks), 128'(3));
        for (int i = 0; i < 5 && i < n_issue; i++)
            chk($sformatf("w2.blk%0d", i), iss_blk[i], {flag1, nonce1, 2'(i)});
        for (int i = 0; i < 3 && i < n_ks; i++)
            chk($sformatf("w2.bytes%0d", i), 128'(ks_bytes[i]), 128'(16));
        chk("w2.ovf_at_issue3", 128'(iss_ovf[3]), 128'(0));
        chk("w2.ovf_at_issue4", 128'(iss_ovf[4]), 128'(1));

        repeat (4) @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        input_en = 1'b0;
        input_last = 1'b0;
        #1;
        chk_rst("w2.midwait_rst");
        n_extra = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            #1;
            if (ain_s || ks_s || s0_s || or_s) n_extra++;
        end
        chk("w2.ignore_late_aes_out", 128'(n_extra), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
